// File: rtl/bsg_clk_gen_bringup_ctrl.sv
// Clock-generator bring-up sequencer.
// Emits the tag packets that bring up each clock-generator endpoint:
// assert the async reset, then for every endpoint park it on the safe
// external clock, program the oscillator, pulse its trigger and load the
// downsampler. It then drops the async reset, waits for the oscillators to
// settle, and switches every endpoint to its final clock select.
module bsg_clk_gen_bringup_ctrl #(
    parameter int         num_clk_endpoint_p = 2,
    parameter int         osc_width_p        = 6,
    parameter int         ds_width_p         = 8,
    parameter int         settle_cycles_p    = 64,
    parameter logic [1:0] sel_safe_p         = 2'b10,
    localparam int data_width_lp =
        ((osc_width_p > ds_width_p + 1 ? osc_width_p : ds_width_p + 1) > 2)
      ?  (osc_width_p > ds_width_p + 1 ? osc_width_p : ds_width_p + 1) : 2,
    localparam int ep_width_lp = (num_clk_endpoint_p > 1) ? $clog2(num_clk_endpoint_p) : 1
) (
    input  logic                                           clk_i,
    input  logic                                           reset_i,
    input  logic                                           start_v_i,
    output logic                                           start_ready_o,
    input  logic [num_clk_endpoint_p-1:0][osc_width_p-1:0] osc_val_i,
    input  logic [num_clk_endpoint_p-1:0][ds_width_p-1:0]  ds_val_i,
    input  logic [num_clk_endpoint_p-1:0][1:0]             sel_final_i,
    output logic                                           pkt_v_o,
    input  logic                                           pkt_ready_i,
    output logic [2:0]                                     pkt_target_o,
    output logic [ep_width_lp-1:0]                         pkt_endpoint_o,
    output logic [data_width_lp-1:0]                       pkt_data_o,
    output logic                                           busy_o,
    output logic                                           done_o
);

    // Snapshot storage is padded to a power of two so the endpoint counter
    // indexes it at its natural width, including the single-endpoint case.
    localparam int ep_slots_lp  = 1 << ep_width_lp;
    localparam int cnt_width_lp = (settle_cycles_p > 1) ? $clog2(settle_cycles_p) : 1;
    localparam logic [cnt_width_lp-1:0] settle_load_lp =
        cnt_width_lp'((settle_cycles_p > 0) ? settle_cycles_p - 1 : 0);
    localparam logic [ep_width_lp-1:0]  ep_last_lp = ep_width_lp'(num_clk_endpoint_p - 1);

    localparam logic [2:0] tgt_async_rst_lp = 3'd0;
    localparam logic [2:0] tgt_osc_lp       = 3'd1;
    localparam logic [2:0] tgt_osc_trig_lp  = 3'd2;
    localparam logic [2:0] tgt_ds_lp        = 3'd3;
    localparam logic [2:0] tgt_sel_lp       = 3'd4;

    typedef enum logic [3:0] {
        IDLE, RST_ON, SAFE_SEL, OSC, TRIG_HI, TRIG_LO, DS,
        RST_OFF, SETTLE, FINAL_SEL, DONE
    } state_e;

    state_e                                    state, state_n;
    logic [ep_width_lp-1:0]                    ep, ep_n;
    logic [cnt_width_lp-1:0]                   cnt, cnt_n;
    logic                                      snap_en, fire;
    logic [ep_slots_lp-1:0][osc_width_p-1:0]   osc_r, osc_pad;
    logic [ep_slots_lp-1:0][ds_width_p-1:0]    ds_r, ds_pad;
    logic [ep_slots_lp-1:0][1:0]               sel_r, sel_pad;
    logic                                      v_n;
    logic [2:0]                                tgt_n;
    logic [data_width_lp-1:0]                  data_n;

    assign fire          = pkt_v_o & pkt_ready_i;
    assign start_ready_o = (state == IDLE);
    assign busy_o        = (state != IDLE);

    // Zero-pad the configuration inputs out to the snapshot depth.
    always_comb begin
        osc_pad = '0;
        ds_pad  = '0;
        sel_pad = '0;
        for (int e = 0; e < num_clk_endpoint_p; e++) begin
            osc_pad[e] = osc_val_i[e];
            ds_pad[e]  = ds_val_i[e];
            sel_pad[e] = sel_final_i[e];
        end
    end

    // Next-state, endpoint and settle-counter logic; packet states only
    // advance on an accepted handshake.
    always_comb begin
        state_n = state;
        ep_n    = ep;
        cnt_n   = cnt;
        snap_en = 1'b0;
        unique case (state)
            IDLE: if (start_v_i) begin
                state_n = RST_ON;
                ep_n    = '0;
                snap_en = 1'b1;
            end
            RST_ON:   if (fire) state_n = SAFE_SEL;
            SAFE_SEL: if (fire) state_n = OSC;
            OSC:      if (fire) state_n = TRIG_HI;
            TRIG_HI:  if (fire) state_n = TRIG_LO;
            TRIG_LO:  if (fire) state_n = DS;
            DS: if (fire) begin
                if (ep == ep_last_lp) begin
                    ep_n    = '0;
                    state_n = RST_OFF;
                end else begin
                    ep_n    = ep + ep_width_lp'(1);
                    state_n = SAFE_SEL;
                end
            end
            RST_OFF: if (fire) begin
                state_n = SETTLE;
                cnt_n   = settle_load_lp;
            end
            SETTLE: begin
                if (cnt == '0) state_n = FINAL_SEL;
                else           cnt_n   = cnt - cnt_width_lp'(1);
            end
            FINAL_SEL: if (fire) begin
                if (ep == ep_last_lp) begin
                    ep_n    = '0;
                    state_n = DONE;
                end else begin
                    ep_n    = ep + ep_width_lp'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Packet fields for the state being entered, so they come out of flops.
    always_comb begin
        v_n    = 1'b1;
        tgt_n  = 3'd0;
        data_n = '0;
        unique case (state_n)
            RST_ON: begin
                tgt_n     = tgt_async_rst_lp;
                data_n[0] = 1'b1;
            end
            SAFE_SEL: begin
                tgt_n       = tgt_sel_lp;
                data_n[1:0] = sel_safe_p;
            end
            OSC: begin
                tgt_n                     = tgt_osc_lp;
                data_n[osc_width_p-1:0]   = osc_r[ep_n];
            end
            TRIG_HI: begin
                tgt_n     = tgt_osc_trig_lp;
                data_n[0] = 1'b1;
            end
            TRIG_LO: tgt_n = tgt_osc_trig_lp;
            DS: begin
                tgt_n                  = tgt_ds_lp;
                data_n[ds_width_p:0]   = {ds_r[ep_n], 1'b0};
            end
            RST_OFF: tgt_n = tgt_async_rst_lp;
            FINAL_SEL: begin
                tgt_n       = tgt_sel_lp;
                data_n[1:0] = sel_r[ep_n];
            end
            default: v_n = 1'b0;
        endcase
    end

    // Sequencer state, snapshot and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state          <= IDLE;
            ep             <= '0;
            cnt            <= '0;
            osc_r          <= '0;
            ds_r           <= '0;
            sel_r          <= '0;
            pkt_v_o        <= 1'b0;
            pkt_target_o   <= '0;
            pkt_endpoint_o <= '0;
            pkt_data_o     <= '0;
            done_o         <= 1'b0;
        end else begin
            state <= state_n;
            ep    <= ep_n;
            cnt   <= cnt_n;
            if (snap_en) begin
                osc_r <= osc_pad;
                ds_r  <= ds_pad;
                sel_r <= sel_pad;
            end
            pkt_v_o        <= v_n;
            pkt_target_o   <= v_n ? tgt_n : 3'd0;
            pkt_endpoint_o <= v_n ? ep_n : '0;
            pkt_data_o     <= data_n;
            done_o         <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_bsg_clk_gen_bringup_ctrl.sv
// Directed bench for the bring-up sequencer: a two-endpoint instance with a
// short settle time and a single-endpoint instance with no settle time.
module tb_bsg_clk_gen_bringup_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Instance A: two endpoints, settle 4
    logic            a_start, a_ready, a_sr, a_v, a_busy, a_done;
    logic [1:0][5:0] a_osc;
    logic [1:0][7:0] a_ds;
    logic [1:0][1:0] a_sel;
    logic [2:0]      a_tgt;
    logic [0:0]      a_ep;
    logic [8:0]      a_data;

    // Instance B: one endpoint, settle 0
    logic            b_start, b_ready, b_sr, b_v, b_busy, b_done;
    logic [0:0][5:0] b_osc;
    logic [0:0][7:0] b_ds;
    logic [0:0][1:0] b_sel;
    logic [2:0]      b_tgt;
    logic [0:0]      b_ep;
    logic [8:0]      b_data;

    bsg_clk_gen_bringup_ctrl #(.num_clk_endpoint_p(2), .settle_cycles_p(4)) dut_a (
        .clk_i(clk), .reset_i(rst), .start_v_i(a_start), .start_ready_o(a_sr),
        .osc_val_i(a_osc), .ds_val_i(a_ds), .sel_final_i(a_sel),
        .pkt_v_o(a_v), .pkt_ready_i(a_ready), .pkt_target_o(a_tgt),
        .pkt_endpoint_o(a_ep), .pkt_data_o(a_data), .busy_o(a_busy), .done_o(a_done));

    bsg_clk_gen_bringup_ctrl #(.num_clk_endpoint_p(1), .settle_cycles_p(0)) dut_b (
        .clk_i(clk), .reset_i(rst), .start_v_i(b_start), .start_ready_o(b_sr),
        .osc_val_i(b_osc), .ds_val_i(b_ds), .sel_final_i(b_sel),
        .pkt_v_o(b_v), .pkt_ready_i(b_ready), .pkt_target_o(b_tgt),
        .pkt_endpoint_o(b_ep), .pkt_data_o(b_data), .busy_o(b_busy), .done_o(b_done));

    int checks = 0;
    int errors = 0;

    // Monitors: log accepted packets, settle cycles, done pulses and any
    // field change while a packet is stalled.
    logic [12:0] a_q[$];
    logic [12:0] b_q[$];
    int a_settle = 0, a_dones = 0, a_viol = 0;
    int b_settle = 0, b_dones = 0;
    logic        a_stall = 1'b0;
    logic [12:0] a_prev = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_v && a_ready) a_q.push_back({a_tgt, a_ep, a_data});
            if (a_busy && !a_v && !a_done) a_settle <= a_settle + 1;
            if (a_done) a_dones <= a_dones + 1;
            if (a_stall && (!a_v || {a_tgt, a_ep, a_data} != a_prev)) a_viol <= a_viol + 1;
            a_stall <= a_v && !a_ready;
            a_prev  <= {a_tgt, a_ep, a_data};
        end else begin
            a_stall <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b_v && b_ready) b_q.push_back({b_tgt, b_ep, b_data});
            if (b_busy && !b_v && !b_done) b_settle <= b_settle + 1;
            if (b_done) b_dones <= b_dones + 1;
        end
    end

    function automatic logic [12:0] pk(input logic [2:0] t, input logic e, input logic [8:0] d);
        return {t, e, d};
    endfunction

    logic [12:0] exp_q[$];

    // Expected 14-packet sequence for instance A.
    task automatic build_exp_a(input logic [5:0] o0, input logic [5:0] o1,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [1:0] s0, input logic [1:0] s1);
        exp_q = {};
        exp_q.push_back(pk(3'd0, 1'b0, 9'd1));
        exp_q.push_back(pk(3'd4, 1'b0, 9'd2));
        exp_q.push_back(pk(3'd1, 1'b0, {3'b0, o0}));
        exp_q.push_back(pk(3'd2, 1'b0, 9'd1));
        exp_q.push_back(pk(3'd2, 1'b0, 9'd0));
        exp_q.push_back(pk(3'd3, 1'b0, {d0, 1'b0}));
        exp_q.push_back(pk(3'd4, 1'b1, 9'd2));
        exp_q.push_back(pk(3'd1, 1'b1, {3'b0, o1}));
        exp_q.push_back(pk(3'd2, 1'b1, 9'd1));
        exp_q.push_back(pk(3'd2, 1'b1, 9'd0));
        exp_q.push_back(pk(3'd3, 1'b1, {d1, 1'b0}));
        exp_q.push_back(pk(3'd0, 1'b0, 9'd0));
        exp_q.push_back(pk(3'd4, 1'b0, {7'b0, s0}));
        exp_q.push_back(pk(3'd4, 1'b1, {7'b0, s1}));
    endtask

    task automatic wait_a_done(input int d0, input string name);
        int n = 0;
        while (a_dones == d0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (a_dones == d0) begin
            errors++;
            $display("FAIL %s timeout: dones %0d required > %0d", name, a_dones, d0);
        end
    endtask

    task automatic pulse_a_start();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic cmp_a_pkts(input int n0, input string name);
        checks++;
        if (a_q.size() - n0 !== 14) begin
            errors++;
            $display("FAIL %s count: got %0d required 14", name, a_q.size() - n0);
        end
        for (int i = 0; i < 14 && n0 + i < a_q.size(); i++) begin
            checks++;
            if (a_q[n0 + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s pkt%0d: got %h required %h", name, i, a_q[n0 + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({a_v, a_busy, a_done, a_tgt, a_ep, a_data} !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %b required 0", {a_v, a_busy, a_done, a_tgt, a_ep, a_data});
        end
        checks++;
        if ({b_v, b_busy, b_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outs_b: got %b required 000", {b_v, b_busy, b_done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (a_sr !== 1'b1 || b_sr !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b%b required 11", a_sr, b_sr);
        end
    endtask

    // Start is already high at the first edge after reset release.
    task automatic test_basic();
        int n0 = a_q.size(), s0 = a_settle, d0 = a_dones;
        build_exp_a(6'h0A, 6'h15, 8'h03, 8'h07, 2'b00, 2'b01);
        pulse_a_start();
        checks++;
        if (a_v !== 1'b1 || a_busy !== 1'b1 || a_sr !== 1'b0) begin
            errors++;
            $display("FAIL basic_first_edge: v/busy/ready %b%b%b required 110", a_v, a_busy, a_sr);
        end
        wait_a_done(d0, "basic");
        repeat (3) @(posedge clk);
        #1;
        cmp_a_pkts(n0, "basic");
        checks++;
        if (a_settle - s0 !== 4) begin
            errors++;
            $display("FAIL basic_settle: got %0d required 4", a_settle - s0);
        end
        checks++;
        if (a_dones - d0 !== 1 || a_busy !== 1'b0 || a_sr !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: dones %0d busy %b ready %b required 1 0 1", a_dones - d0, a_busy, a_sr);
        end
    endtask

    task automatic test_backpressure();
        int n0 = a_q.size(), v0 = a_viol, d0 = a_dones, k = 0;
        logic [3:0] pat = 4'b1001;
        build_exp_a(6'h0A, 6'h15, 8'h03, 8'h07, 2'b00, 2'b01);
        pulse_a_start();
        while (a_dones == d0 && k < 300) begin
            a_ready = pat[k % 4];
            @(posedge clk); #1;
            k++;
        end
        a_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmp_a_pkts(n0, "bp");
        checks++;
        if (a_viol - v0 !== 0) begin
            errors++;
            $display("FAIL bp_stable: %0d field changes while stalled, required 0", a_viol - v0);
        end
        checks++;
        if (a_dones - d0 !== 1) begin
            errors++;
            $display("FAIL bp_done: got %0d required 1", a_dones - d0);
        end
    endtask

    task automatic test_snapshot();
        int n0 = a_q.size(), d0 = a_dones;
        build_exp_a(6'h0A, 6'h15, 8'h03, 8'h07, 2'b00, 2'b01);
        pulse_a_start();
        a_osc = {6'h3F, 6'h3F};
        wait_a_done(d0, "snap");
        a_osc = {6'h15, 6'h0A};
        repeat (2) @(posedge clk);
        #1;
        cmp_a_pkts(n0, "snap");
    endtask

    task automatic test_reset_mid();
        int n0 = a_q.size(), n1, d0, k = 0;
        pulse_a_start();
        while (!(a_v && a_tgt == 3'd2 && a_ep == 1'b1 && a_data == 9'd1) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (a_v !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outs: v/busy/done %b%b%b required 000", a_v, a_busy, a_done);
        end
        n1 = a_q.size();
        checks++;
        if (n1 - n0 !== 8) begin
            errors++;
            $display("FAIL rstmid_count: got %0d required 8", n1 - n0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (a_q.size() !== n1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: pkts %0d busy %b required %0d 0", a_q.size(), a_busy, n1);
        end
        d0 = a_dones;
        build_exp_a(6'h0A, 6'h15, 8'h03, 8'h07, 2'b00, 2'b01);
        pulse_a_start();
        wait_a_done(d0, "rstmid");
        repeat (2) @(posedge clk);
        #1;
        cmp_a_pkts(n1, "rstmid");
    endtask

    task automatic test_start_busy();
        int n0 = a_q.size(), s0 = a_settle, d0 = a_dones, k = 0, bad = 0;
        build_exp_a(6'h0A, 6'h15, 8'h03, 8'h07, 2'b00, 2'b01);
        pulse_a_start();
        a_start = 1'b1;
        while (a_settle - s0 < 3 && k < 200) begin
            if (a_sr !== 1'b0) bad++;
            @(posedge clk); #1;
            k++;
        end
        if (a_sr !== 1'b0) bad++;
        a_start = 1'b0;
        wait_a_done(d0, "busy");
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL busy_ready: start_ready high %0d times while busy, required 0", bad);
        end
        checks++;
        if (a_dones - d0 !== 1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_done: dones %0d busy %b required 1 0", a_dones - d0, a_busy);
        end
        cmp_a_pkts(n0, "busy");
    endtask

    task automatic test_edge();
        int n0 = b_q.size(), s0 = b_settle, d0 = b_dones, k = 0;
        logic [12:0] e[8];
        e[0] = pk(3'd0, 1'b0, 9'd1);
        e[1] = pk(3'd4, 1'b0, 9'd2);
        e[2] = pk(3'd1, 1'b0, 9'h02C);
        e[3] = pk(3'd2, 1'b0, 9'd1);
        e[4] = pk(3'd2, 1'b0, 9'd0);
        e[5] = pk(3'd3, 1'b0, 9'h0B4);
        e[6] = pk(3'd0, 1'b0, 9'd0);
        e[7] = pk(3'd4, 1'b0, 9'd3);
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        while (b_dones == d0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (b_q.size() - n0 !== 8) begin
            errors++;
            $display("FAIL edge_count: got %0d required 8", b_q.size() - n0);
        end
        for (int i = 0; i < 8 && n0 + i < b_q.size(); i++) begin
            checks++;
            if (b_q[n0 + i] !== e[i]) begin
                errors++;
                $display("FAIL edge_pkt%0d: got %h required %h", i, b_q[n0 + i], e[i]);
            end
        end
        checks++;
        if (b_settle - s0 !== 1) begin
            errors++;
            $display("FAIL edge_settle: got %0d required 1", b_settle - s0);
        end
        checks++;
        if (b_dones - d0 !== 1) begin
            errors++;
            $display("FAIL edge_done: got %0d required 1", b_dones - d0);
        end
    endtask

    initial begin
        a_start = 1'b0; a_ready = 1'b1;
        a_osc = {6'h15, 6'h0A}; a_ds = {8'h07, 8'h03}; a_sel = {2'b01, 2'b00};
        b_start = 1'b0; b_ready = 1'b1;
        b_osc[0] = 6'h2C; b_ds[0] = 8'h5A; b_sel[0] = 2'b11;
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_reset_mid();
        test_start_busy();
        test_edge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_clk_gen_bringup_ctrl.md
BSG_CLK_GEN_BRINGUP_CTRL -- requirements
Module: bsg_clk_gen_bringup_ctrl

Interface
REQ-001 Parameter num_clk_endpoint_p, default 2: number of clock-generator endpoints sequenced.
REQ-002 Parameter osc_width_p, default 6: oscillator setting width.
REQ-003 Parameter ds_width_p, default 8: downsampler value width; the DS payload is ds_width_p+1 bits, with bit 0 as the DS reset bit.
REQ-004 Parameter settle_cycles_p, default 64: number of clk_i cycles to wait after the oscillator reset is deasserted.
REQ-005 Parameter sel_safe_p, default 2'b10: select code for the external clock, used during programming.
REQ-006 Derived width data_width_lp = max(osc_width_p, ds_width_p+1, 2).
REQ-007 Port clk_i, input, 1: the single clock.
REQ-008 Port reset_i, input, 1: reset, asynchronous, active-high.
REQ-009 Port start_v_i, input, 1: bring-up request.
REQ-010 Port start_ready_o, input-side handshake, output, 1: high only in IDLE.
REQ-011 Port osc_val_i, input, num_clk_endpoint_p x osc_width_p: per-endpoint oscillator setting.
REQ-012 Port ds_val_i, input, num_clk_endpoint_p x ds_width_p: per-endpoint downsample value.
REQ-013 Port sel_final_i, input, num_clk_endpoint_p x 2: per-endpoint final clock select.
REQ-014 Port pkt_v_o, output, 1: a tag packet is valid.
REQ-015 Port pkt_ready_i, input, 1: the downstream tag master accepts the packet.
REQ-016 Port pkt_target_o, output, 3: packet target; 0=ASYNC_RST, 1=OSC, 2=OSC_TRIG, 3=DS, 4=SEL.
REQ-017 Port pkt_endpoint_o, output, `safe_clog2(num_clk_endpoint_p)`: endpoint index.
REQ-018 Port pkt_data_o, output, data_width_lp: packet payload, zero-extended.
REQ-019 Port busy_o, output, 1: high whenever the state is not IDLE.
REQ-020 Port done_o, output, 1: one-cycle pulse when bring-up completes.

Function
REQ-021 The block SHALL have these states: IDLE, RST_ON, SAFE_SEL, OSC, TRIG_HI, TRIG_LO, DS, RST_OFF, SETTLE, FINAL_SEL, DONE.
REQ-022 In IDLE, start_v_i & start_ready_o SHALL snapshot osc_val_i, ds_val_i and sel_final_i into registers, clear the endpoint counter, and move to RST_ON; later input changes SHALL NOT affect the sequence.
REQ-023 start_v_i SHALL be ignored in every state other than IDLE.
REQ-024 Each packet state SHALL drive pkt_v_o=1 with stable target, endpoint and data until pkt_v_o & pkt_ready_i; the state SHALL advance only on that handshake, and pkt_v_o SHALL NOT depend combinationally on pkt_ready_i.
REQ-025 RST_ON SHALL send ASYNC_RST with data=1 and endpoint=0.
REQ-026 For each endpoint e, ascending, the block SHALL send, in order:
- SAFE_SEL: SEL with data=sel_safe_p;
- OSC: OSC with data=osc_val[e];
- TRIG_HI: OSC_TRIG with data=1;
- TRIG_LO: OSC_TRIG with data=0;
- DS: DS with data={ds_val[e],1'b0}.
REQ-027 After the DS handshake, the block SHALL go to SAFE_SEL with e+1 if e < num_clk_endpoint_p-1; otherwise it SHALL clear e and go to RST_OFF.
REQ-028 RST_OFF SHALL send ASYNC_RST with data=0.
REQ-029 After RST_OFF is accepted, SETTLE SHALL load a down-counter with settle_cycles_p-1 and decrement it each cycle; it SHALL move to FINAL_SEL on the cycle the counter reads 0, giving exactly settle_cycles_p cycles in SETTLE.
REQ-030 If settle_cycles_p=0, SETTLE SHALL last one cycle.
REQ-031 pkt_v_o SHALL be 0 in SETTLE.
REQ-032 FINAL_SEL SHALL send SEL with data=sel_final[e] for each e ascending; after the last endpoint it SHALL go to DONE.
REQ-033 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-034 A full bring-up SHALL issue exactly 6*num_clk_endpoint_p+2 packets.
REQ-035 The endpoint counter SHALL never exceed num_clk_endpoint_p-1; num_clk_endpoint_p=1 SHALL work, with a zero-width index treated as 0.
REQ-036 If pkt_ready_i is held low indefinitely, the block SHALL hold its packet without timeout.
REQ-037 pkt_ready_i asserted while pkt_v_o=0 SHALL have no effect.

Reset
REQ-038 reset_i high SHALL asynchronously force IDLE, pkt_v_o=0, done_o=0, busy_o=0, target/endpoint/data=0, counters=0 and snapshot registers=0.
REQ-039 After reset_i is released, start_ready_o SHALL be 1.
REQ-040 Reset mid-sequence SHALL abandon the sequence with no further packets; the next start SHALL begin again at RST_ON.
REQ-041 The first start SHALL be accepted on the first clk_i edge after reset_i falls.

Verification
REQ-042 Scenario, basic bring-up: num=2, settle=4, pkt_ready_i=1, osc={6'h0A,6'h15}, ds={8'h03,8'h07}, sel_final={2'b00,2'b01}, start pulse -> 14 packets in order:
- ASYNC_RST/1;
- endpoint 0: SEL/2, OSC/0x0A, TRIG/1, TRIG/0, DS/0x006;
- endpoint 1: SEL/2, OSC/0x15, TRIG/1, TRIG/0, DS/0x00E;
- ASYNC_RST/0;
- 4 idle cycles;
- SEL e0/0, SEL e1/1;
- done_o pulse for 1 cycle.
REQ-043 Scenario, backpressure: pkt_ready_i toggling 1,0,0,1 -> identical packet order; fields stable while pkt_v_o=1 and pkt_ready_i=0; no packet dropped or duplicated.
REQ-044 Scenario, snapshot: change osc_val_i to 6'h3F one cycle after start -> OSC packets still carry 0x0A and 0x15.
REQ-045 Scenario, reset during TRIG_HI of endpoint 1 -> pkt_v_o=0 immediately, busy_o=0; a new start produces a full 14-packet sequence.
REQ-046 Scenario, start while busy: start_v_i=1 during SETTLE -> ignored; exactly one done_o; start_ready_o=0 until IDLE.
REQ-047 Scenario, edge configuration: num=1, settle=0 -> 8 packets, SETTLE lasts 1 cycle, done_o pulses once.
